// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flip-flop, LSB first.
// Start/busy/done handshake. The result holds until the final bit of the next operation.
`timescale 1ns/1ps
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-2:0]   s_sh_q, s_sh_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    // Full-adder cell driven from the shift-register LSBs and the carry flop
    logic fa_x, fa_y, fa_cin, fa_sum, fa_carry;
    assign fa_x     = a_sh_q[0];
    assign fa_y     = b_sh_q[0];
    assign fa_cin   = c_q;
    assign fa_sum   = fa_x ^ fa_y ^ fa_cin;
    assign fa_carry = (fa_x & fa_y) | (fa_cin & (fa_x ^ fa_y));

    // New sum bit enters at the MSB; the full word is valid on the last RUN edge
    logic [WIDTH-1:0] s_cat;
    assign s_cat = {fa_sum, s_sh_q};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sh_d  = a_in;
                    b_sh_d  = b_in;
                    c_d     = cin_in;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                s_sh_d = s_cat[WIDTH-1:1];
                c_d    = fa_carry;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LastBit) begin
                    sum_d   = s_cat;
                    cout_d  = fa_carry;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: vector table at WIDTH=8, handshake/reset sequences,
// exhaustive WIDTH=4 sweep.
`timescale 1ns/1ps
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start4, cin4;
    logic [3:0] a4, b4;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .a_in   (a8),
        .b_in   (b8),
        .cin_in (cin8),
        .busy   (busy8),
        .done   (done8),
        .sum    (sum8),
        .cout   (cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start4),
        .a_in   (a4),
        .b_in   (b4),
        .cin_in (cin4),
        .busy   (busy4),
        .done   (done4),
        .sum    (sum4),
        .cout   (cout4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // One WIDTH=8 operation; operands are scrambled right after the accept edge.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output logic [7:0] s, output logic co, output int lat);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~c;
        lat = 1;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        s = sum8; co = cout8;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c,
                        output logic [3:0] s, output logic co, output int lat);
        @(negedge clk);
        a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; a4 = ~a; b4 = ~b;
        lat = 1;
        while (!done4 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        s = sum4; co = cout4;
    endtask

    initial begin
        logic [7:0] s;
        logic       co;
        logic [3:0] s4;
        logic       co4;
        logic [8:0] e3[3];
        int lat, ndone, last, first;
        logic prev_done;

        vecs[0]  = '{8'd5,   8'd3,   1'b0, 8'd8,   1'b0};
        vecs[1]  = '{8'd200, 8'd100, 1'b0, 8'd44,  1'b1};
        vecs[2]  = '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1};
        vecs[3]  = '{8'd0,   8'd0,   1'b1, 8'd1,   1'b0};
        vecs[4]  = '{8'd0,   8'd0,   1'b0, 8'd0,   1'b0};
        vecs[5]  = '{8'd255, 8'd1,   1'b0, 8'd0,   1'b1};
        vecs[6]  = '{8'd170, 8'd85,  1'b0, 8'd255, 1'b0};
        vecs[7]  = '{8'd170, 8'd85,  1'b1, 8'd0,   1'b1};
        vecs[8]  = '{8'd128, 8'd128, 1'b0, 8'd0,   1'b1};
        vecs[9]  = '{8'd15,  8'd241, 1'b0, 8'd0,   1'b1};
        vecs[10] = '{8'd100, 8'd27,  1'b1, 8'd128, 1'b0};

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        #1;
        check("reset_busy", busy8, 0);
        check("reset_done", done8, 0);
        check("reset_sum_cout", {cout8, sum8}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors: result and latency (done in 9th cycle after accept)
        for (int i = 0; i < 11; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, lat);
            check($sformatf("vec%0d_result", i), {co, s}, {vecs[i].co, vecs[i].s});
            check($sformatf("vec%0d_latency", i), lat, 9);
        end
        @(negedge clk);
        check("idle_busy", busy8, 0);

        // start held high: period 10, operand changes mid-RUN are not seen
        e3[0] = 9'h01E; e3[1] = 9'h083; e3[2] = 9'h104;
        @(negedge clk);
        a8 = 8'd10; b8 = 8'd20; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        ndone = 0; last = 0; first = 0; prev_done = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (done8) begin
                check("s3_no_double_done", prev_done, 0);
                if (ndone == 0) first = i;
                else check("s3_period", i - last, 10);
                if (ndone < 3) check($sformatf("s3_result%0d", ndone), {cout8, sum8}, e3[ndone]);
                last = i;
                ndone++;
            end
            prev_done = done8;
            if (i == 3) begin a8 = 8'd60; b8 = 8'd70; cin8 = 1'b1; end
            if (i == 13) begin a8 = 8'd250; b8 = 8'd10; cin8 = 1'b0; end
            if (i == 29) start8 = 1'b0;
        end
        check("s3_first_done", first, 9);
        check("s3_done_count", ndone, 3);
        check("s3_idle_busy", busy8, 0);

        // Extra start pulses in RUN and DONE ignored; result holds until final edge
        @(negedge clk);
        a8 = 8'd7; b8 = 8'd9; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        ndone = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check($sformatf("s4_busy%0d", i), busy8, (i <= 9));
            if (i <= 8) check($sformatf("s4_hold%0d", i), {cout8, sum8}, 9'h104);
            else check($sformatf("s4_result%0d", i), {cout8, sum8}, 9'd16);
            if (done8) ndone++;
            start8 = (i == 2 || i == 5 || i == 8 || i == 9);
            a8 = 8'(i * 37); b8 = 8'(i * 11);
        end
        check("s4_done_count", ndone, 1);

        // Async reset at RUN bit 4
        @(negedge clk);
        a8 = 8'd100; b8 = 8'd50; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("s5_busy", busy8, 0);
        check("s5_done", done8, 0);
        check("s5_sum_cout", {cout8, sum8}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done8 || busy8) ndone++;
        end
        check("s5_no_activity", ndone, 0);
        run8(8'd99, 8'd201, 1'b1, s, co, lat);
        check("s5_after_reset", {co, s}, 9'd301);
        check("s5_latency", lat, 9);

        // Exhaustive WIDTH=4: {latency, cout, sum}
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    run4(4'(a), 4'(b), c[0], s4, co4, lat);
                    check($sformatf("exh_%0d_%0d_%0d", a, b, c),
                          (64'(lat) << 5) | 64'({co4, s4}),
                          (64'd5 << 5) | 64'(a + b + c));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
